// File: rtl/sdram_stream_feeder.sv
// rtl/sdram_stream_feeder.sv - write FIFO + read-request arbiter issuing paced wr_en/rd_en pulses to the SDRAM controller
// Optional issue/return counters: define SDRAM_FEEDER_STATS_EN.
module sdram_stream_feeder #(
   parameter int DEPTH      = 16,
   parameter int PEND_W     = 4,
   parameter int GAP_CYCLES = 1,
   parameter int RD_LATENCY = 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       wr_valid,
   input  logic [15:0]                wr_data,
   output logic                       wr_ready,
   input  logic                       rd_req,
   output logic                       rd_req_ready,
   output logic                       rd_valid,
   output logic [15:0]                rd_data,
   output logic                       mem_wr_en,
   output logic                       mem_rd_en,
   output logic [15:0]                mem_data_in,
   input  logic [15:0]                mem_data_out,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       busy
`ifdef SDRAM_FEEDER_STATS_EN
   ,
   output logic [15:0]                wr_count,
   output logic [15:0]                rd_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int GW = $clog2(GAP_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t                state;
   logic [15:0]           fifo_mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           count, count_next;
   logic                  full, empty;
   logic [PEND_W-1:0]     pend;
   logic                  last_rd;
   logic [GW-1:0]         gap_cnt;
   logic [RD_LATENCY-1:0] rd_pipe;
   logic                  push, pop, rd_acc;

   assign wr_ready     = ~full;
   assign rd_req_ready = ~&pend;
   assign push         = wr_valid & ~full;
   // The write pulse itself is the pop: the head word leaves as it is presented to the controller.
   assign pop          = mem_wr_en;
   assign rd_acc       = rd_req & rd_req_ready;
   assign fifo_level   = count;
   assign busy         = (state != IDLE) | ~empty | (pend != '0);

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + 1'b1;
      else if (!push && pop)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         full  <= (count_next == (AW+1)'(DEPTH));
         empty <= (count_next == '0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         pend <= '0;
      else if (rd_acc && !mem_rd_en)
         pend <= pend + 1'b1;
      else if (!rd_acc && mem_rd_en)
         pend <= pend - 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         mem_wr_en   <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_data_in <= '0;
         last_rd     <= 1'b0;
         gap_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty || pend != '0) begin
                  state <= ISSUE;
                  // With both sources ready, take the one not served last time.
                  if (!empty && (pend == '0 || last_rd)) begin
                     mem_wr_en   <= 1'b1;
                     mem_data_in <= fifo_mem[rd_ptr];
                  end else begin
                     mem_rd_en <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               mem_wr_en <= 1'b0;
               mem_rd_en <= 1'b0;
               last_rd   <= mem_rd_en;
               gap_cnt   <= GW'(GAP_CYCLES - 1);
               state     <= GAP;
            end
            GAP: begin
               if (gap_cnt == '0)
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pipe  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_pipe[0] <= mem_rd_en;
         for (int i = 1; i < RD_LATENCY; i++)
            rd_pipe[i] <= rd_pipe[i-1];
         rd_valid <= rd_pipe[RD_LATENCY-1];
         if (rd_pipe[RD_LATENCY-1])
            rd_data <= mem_data_out;
      end
   end

`ifdef SDRAM_FEEDER_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         if (mem_wr_en)
            wr_count <= wr_count + 1'b1;
         if (rd_pipe[RD_LATENCY-1])
            rd_count <= rd_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sdram_stream_feeder.sv
// tb/tb_sdram_stream_feeder.sv - randomized bench with queue-based reference model for sdram_stream_feeder
module tb_sdram_stream_feeder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wr_valid, rd_req;
   logic [15:0] wr_data;
   logic        wr_ready, rd_req_ready, rd_valid;
   logic [15:0] rd_data;
   logic        mem_wr_en, mem_rd_en;
   logic [15:0] mem_data_in, mem_data_out;
   logic [4:0]  fifo_level;
   logic        busy;
`ifdef SDRAM_FEEDER_STATS_EN
   logic [15:0] wr_count, rd_count;
`endif

   sdram_stream_feeder dut (
      .clk(clk), .reset_n(reset_n),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_req(rd_req), .rd_req_ready(rd_req_ready),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .fifo_level(fifo_level), .busy(busy)
`ifdef SDRAM_FEEDER_STATS_EN
      , .wr_count(wr_count), .rd_count(rd_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: FIFO contents, pending count, controller memory with a shared address counter.
   logic [15:0] q[$];
   int          pend;
   logic        last_rd;
   int          since;
   logic        prev_q_nz, prev_pend_nz;
   logic [15:0] last_wdata;
   logic [15:0] bmem [256];
   logic [7:0]  addr = 8'd0;
   int          cyc = 0;
   logic [15:0] ret_d[$];
   int          ret_t[$];
   int          wcnt, rcnt;
   int          saw_full = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete(); ret_d.delete(); ret_t.delete();
      pend = 0; last_rd = 1'b0; since = 2;
      prev_q_nz = 1'b0; prev_pend_nz = 1'b0;
      last_wdata = 16'h0; wcnt = 0; rcnt = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_ready"}, wr_ready, 1);
      check({tag, "_rd_req_ready"}, rd_req_ready, 1);
      check({tag, "_rd_valid"}, rd_valid, 0);
      check({tag, "_rd_data"}, rd_data, 0);
      check({tag, "_mem_wr_en"}, mem_wr_en, 0);
      check({tag, "_mem_rd_en"}, mem_rd_en, 0);
      check({tag, "_mem_data_in"}, mem_data_in, 0);
      check({tag, "_fifo_level"}, fifo_level, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   // Called at a negedge with inputs already driven; checks this cycle, then advances one clock.
   task automatic step();
      logic exp_pulse, exp_rd, exp_wr, push_ok, acc;
      if (since < 1000) since++;
      exp_pulse = (since >= 3) && (prev_q_nz || prev_pend_nz);
      exp_rd    = prev_pend_nz && (!prev_q_nz || !last_rd);
      exp_wr    = exp_pulse && !exp_rd;
      check("wr_pulse", mem_wr_en, exp_wr);
      check("rd_pulse", mem_rd_en, exp_pulse && exp_rd);
      if (exp_wr) begin
         check("wr_word", mem_data_in, q[0]);
         last_wdata = q[0];
         bmem[addr] = q[0];
         addr++;
         wcnt++;
      end else begin
         check("data_in_hold", mem_data_in, last_wdata);
      end
      if (exp_pulse && exp_rd) begin
         mem_data_out = bmem[addr];
         ret_d.push_back(bmem[addr]);
         ret_t.push_back(cyc + 2);
         addr++;
      end
      if (exp_pulse) begin
         since   = 0;
         last_rd = exp_rd;
      end
      if (ret_t.size() > 0 && ret_t[0] == cyc) begin
         check("rd_valid", rd_valid, 1);
         check("rd_data", rd_data, ret_d[0]);
         void'(ret_d.pop_front());
         void'(ret_t.pop_front());
         rcnt++;
      end else begin
         check("rd_valid_idle", rd_valid, 0);
      end
      check("wr_ready", wr_ready, q.size() < 16);
      check("rd_req_ready", rd_req_ready, pend < 15);
      check("fifo_level", fifo_level, q.size());
      check("busy", busy, (q.size() > 0) || (pend > 0) || (since < 2));
`ifdef SDRAM_FEEDER_STATS_EN
      check("wr_count", wr_count, wcnt & 16'hFFFF);
      check("rd_count", rd_count, rcnt & 16'hFFFF);
`endif
      if (q.size() == 16) saw_full = 1;
      prev_q_nz    = q.size() > 0;
      prev_pend_nz = pend > 0;
      push_ok = wr_valid && (q.size() < 16);
      acc     = rd_req && (pend < 15);
      @(posedge clk);
      if (exp_wr) void'(q.pop_front());
      if (push_ok) q.push_back(wr_data);
      pend = pend + (acc ? 1 : 0) - ((exp_pulse && exp_rd) ? 1 : 0);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle_steps(input int n);
      wr_valid = 1'b0;
      rd_req   = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) bmem[i] = 16'($urandom);
      reset_n = 1'b0; wr_valid = 1'b0; rd_req = 1'b0; wr_data = 16'h0; mem_data_out = 16'h0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      reset_n = 1'b1;

      // Three back-to-back words: pulses spaced GAP_CYCLES+2 apart carrying A1..A3.
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = 16'hA1 + 16'(i);
         step();
      end
      idle_steps(15);

      // Push continuously until the FIFO fills, then drain.
      wr_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         wr_data = 16'($urandom);
         step();
      end
      check("fifo_reached_full", saw_full, 1);
      idle_steps(60);

      // One read first so the next pair alternates starting with a write.
      rd_req = 1'b1;
      step();
      idle_steps(6);
      wr_valid = 1'b1; rd_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         wr_data = 16'hB0 + 16'(i);
         step();
      end
      idle_steps(20);

      // Saturate the pending-read counter.
      rd_req = 1'b1;
      for (int i = 0; i < 50; i++) step();
      idle_steps(60);

      // Random mixed traffic.
      for (int i = 0; i < 400; i++) begin
         wr_valid = ($urandom_range(0, 2) == 0);
         rd_req   = ($urandom_range(0, 2) == 0);
         wr_data  = 16'($urandom);
         step();
      end

      // Reset in the middle of a read issue; the pending return must be dropped.
      for (int i = 0; i < 60 && !mem_rd_en; i++) begin
         wr_valid = $urandom_range(0, 1) == 1;
         rd_req   = 1'b1;
         wr_data  = 16'($urandom);
         step();
      end
      check("reset_trigger_rd_en", mem_rd_en, 1);
      wr_valid = 1'b0; rd_req = 1'b0;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("mid_issue");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_reset_outputs("held");
      end
      reset_n = 1'b1;
      model_reset();
      idle_steps(5);

      for (int i = 0; i < 150; i++) begin
         wr_valid = ($urandom_range(0, 1) == 0);
         rd_req   = ($urandom_range(0, 3) == 0);
         wr_data  = 16'($urandom);
         step();
      end
      idle_steps(80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
